// File: rtl/receptor_pkg.sv
// Shared symbol constants, control codes and FSM encodings for the 4-lane receive path.
package receptor_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned LANES   = 4;
    localparam int unsigned GROUP_W = BYTE_W * LANES;
    localparam int unsigned CODE_W  = 4;
    localparam int unsigned IDX_W   = 2;

    localparam logic [BYTE_W-1:0] COM  = 8'hBC;
    localparam logic [BYTE_W-1:0] SKP  = 8'h1C;
    localparam logic [BYTE_W-1:0] STP  = 8'hFB;
    localparam logic [BYTE_W-1:0] SDP  = 8'h5C;
    localparam logic [BYTE_W-1:0] END  = 8'hFD;
    localparam logic [BYTE_W-1:0] EDB  = 8'hFE;
    localparam logic [BYTE_W-1:0] FTS  = 8'h3C;
    localparam logic [BYTE_W-1:0] IDLE = 8'h7C;

    typedef enum logic [CODE_W-1:0] {
        DK_DATA = 4'b0000,
        DK_COM  = 4'b0001,
        DK_SKP  = 4'b0010,
        DK_STP  = 4'b0011,
        DK_SDP  = 4'b0100,
        DK_END  = 4'b0101,
        DK_EDB  = 4'b0110,
        DK_FTS  = 4'b0111,
        DK_IDLE = 4'b1000
    } dk_code_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TLP  = 2'd1,
        S_DLLP = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic [BYTE_W-1:0] data;
        dk_code_e          code;
        logic              valid;
        logic              tlp;
        logic              dllp;
        logic              ferr;
    } rx_out_t;

    // Inside a packet only the terminators are symbols; everything else is payload.
    function automatic dk_code_e decode_sym(input logic [BYTE_W-1:0] b, input logic in_pkt);
        dk_code_e c;
        c = DK_DATA;
        case (b)
            END:     c = DK_END;
            EDB:     c = DK_EDB;
            COM:     c = in_pkt ? DK_DATA : DK_COM;
            SKP:     c = in_pkt ? DK_DATA : DK_SKP;
            STP:     c = in_pkt ? DK_DATA : DK_STP;
            SDP:     c = in_pkt ? DK_DATA : DK_SDP;
            FTS:     c = in_pkt ? DK_DATA : DK_FTS;
            IDLE:    c = in_pkt ? DK_DATA : DK_IDLE;
            default: c = DK_DATA;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/receptor_if.sv
// Lane-group input and decoded byte-stream output bundle of the receiver.
interface receptor_if;
    import receptor_pkg::*;

    logic [BYTE_W-1:0] rx_lane0;
    logic [BYTE_W-1:0] rx_lane1;
    logic [BYTE_W-1:0] rx_lane2;
    logic [BYTE_W-1:0] rx_lane3;
    logic              rx_lanes_valid;
    logic [BYTE_W-1:0] rx_byte;
    logic [CODE_W-1:0] control_dk;
    logic              rx_byte_valid;
    logic              in_tlp;
    logic              in_dllp;
    logic              framing_err;
    logic              overflow;

    modport master (
        output rx_lane0, rx_lane1, rx_lane2, rx_lane3, rx_lanes_valid,
        input  rx_byte, control_dk, rx_byte_valid, in_tlp, in_dllp, framing_err, overflow
    );

    modport slave (
        input  rx_lane0, rx_lane1, rx_lane2, rx_lane3, rx_lanes_valid,
        output rx_byte, control_dk, rx_byte_valid, in_tlp, in_dllp, framing_err, overflow
    );

endinterface

// File: rtl/receptor_byte_unstriping.sv
// Ping-pong buffer of two lane groups, serialised lane 0..3 one byte per enabled cycle.
module receptor_byte_unstriping
    import receptor_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              enb,
    input  logic [BYTE_W-1:0] lane0,
    input  logic [BYTE_W-1:0] lane1,
    input  logic [BYTE_W-1:0] lane2,
    input  logic [BYTE_W-1:0] lane3,
    input  logic              lanes_valid,
    output logic [BYTE_W-1:0] byte_c,
    output logic              byte_valid_c,
    output logic              overflow
);

    logic [GROUP_W-1:0] slot_q [2];
    logic [1:0]         full_q;
    logic               wr_sel_q;
    logic               rd_sel_q;
    logic [IDX_W-1:0]   rd_idx_q;
    logic               overflow_q;

    logic               rd_fire;
    logic               rd_last;
    logic               wr_req;
    logic               wr_ok;
    logic [GROUP_W-1:0] rd_grp;

    // Full slots are always contiguous from rd_sel, so a full write slot is the one being read.
    assign rd_fire = enb && full_q[rd_sel_q];
    assign rd_last = rd_fire && (rd_idx_q == IDX_W'(LANES - 1));
    assign wr_req  = enb && lanes_valid;
    assign wr_ok   = wr_req && (!full_q[wr_sel_q] || rd_last);
    assign rd_grp  = slot_q[rd_sel_q];

    always_comb begin
        byte_c = rd_grp[GROUP_W-1 -: BYTE_W];
        case (rd_idx_q)
            2'd0:    byte_c = rd_grp[31:24];
            2'd1:    byte_c = rd_grp[23:16];
            2'd2:    byte_c = rd_grp[15:8];
            default: byte_c = rd_grp[7:0];
        endcase
    end

    assign byte_valid_c = rd_fire;
    assign overflow     = overflow_q;

    // Free-before-fill ordering lets a slot released by the last read accept the new group.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q[0]  <= '0;
            slot_q[1]  <= '0;
            full_q     <= '0;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            rd_idx_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (rd_fire) begin
                rd_idx_q <= rd_idx_q + IDX_W'(1);
            end
            if (rd_last) begin
                rd_sel_q         <= ~rd_sel_q;
                full_q[rd_sel_q] <= 1'b0;
            end
            if (wr_ok) begin
                slot_q[wr_sel_q] <= {lane0, lane1, lane2, lane3};
                full_q[wr_sel_q] <= 1'b1;
                wr_sel_q         <= ~wr_sel_q;
            end
            if (wr_req && !wr_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/receptor.sv
// 4-lane receiver: un-stripes lane groups, decodes control symbols and tracks packet framing.
module receptor
    import receptor_pkg::*;
#(
    parameter bit SKP_DROP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    receptor_if.slave  bus
);

    logic [BYTE_W-1:0] sel_byte_c;
    logic              sel_valid_c;
    logic              overflow;

    rx_state_e state_q;
    rx_state_e state_d;
    rx_out_t   out_q;
    rx_out_t   out_d;
    dk_code_e  code_c;
    logic      drop_c;

    receptor_byte_unstriping u_unstripe (
        .clk         (clk),
        .rst         (rst),
        .enb         (enb),
        .lane0       (bus.rx_lane0),
        .lane1       (bus.rx_lane1),
        .lane2       (bus.rx_lane2),
        .lane3       (bus.rx_lane3),
        .lanes_valid (bus.rx_lanes_valid),
        .byte_c      (sel_byte_c),
        .byte_valid_c(sel_valid_c),
        .overflow    (overflow)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    // Framing FSM advances only on emitted bytes; packet flags span start through terminator.
    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        out_d.valid = 1'b0;
        out_d.ferr  = 1'b0;
        out_d.tlp   = (state_q == S_TLP);
        out_d.dllp  = (state_q == S_DLLP);
        code_c     = decode_sym(sel_byte_c, state_q != S_IDLE);
        drop_c     = SKP_DROP && (code_c == DK_SKP);

        if (sel_valid_c) begin
            if (!drop_c) begin
                out_d.data  = sel_byte_c;
                out_d.code  = code_c;
                out_d.valid = 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    case (code_c)
                        DK_STP:                  state_d = S_TLP;
                        DK_SDP:                  state_d = S_DLLP;
                        DK_DATA, DK_END, DK_EDB: out_d.ferr = 1'b1;
                        default:                 state_d = S_IDLE;
                    endcase
                end
                S_TLP, S_DLLP: begin
                    if (code_c == DK_END || code_c == DK_EDB) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            out_d.tlp  = (state_q == S_TLP)  || (state_d == S_TLP);
            out_d.dllp = (state_q == S_DLLP) || (state_d == S_DLLP);
        end
    end

    assign bus.rx_byte       = out_q.data;
    assign bus.control_dk    = out_q.code;
    assign bus.rx_byte_valid = out_q.valid;
    assign bus.in_tlp        = out_q.tlp;
    assign bus.in_dllp       = out_q.dllp;
    assign bus.framing_err   = out_q.ferr;
    assign bus.overflow      = overflow;

endmodule

// File: tb/tb_receptor.sv
// Scoreboard bench for receptor: two instances (SKP dropped / SKP kept) share one stimulus.
`timescale 1ns/1ps
module tb_receptor;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enb = 1'b0;

    always #5 clk = ~clk;

    receptor_if bus_d ();
    receptor_if bus_k ();

    receptor #(.SKP_DROP(1'b1)) u_drop (.clk(clk), .rst(rst), .enb(enb), .bus(bus_d));
    receptor #(.SKP_DROP(1'b0)) u_keep (.clk(clk), .rst(rst), .enb(enb), .bus(bus_k));

    typedef struct {
        logic [7:0] b;
        logic [3:0] code;
        logic       tlp;
        logic       dllp;
        logic       ferr;
    } exp_t;

    exp_t q_d[$];
    exp_t q_k[$];
    int checks = 0;
    int errors = 0;

    // Expected byte for both instances; SKP-coded bytes never reach the dropping instance.
    task automatic push_exp(input logic [7:0] b, input logic [3:0] code,
                            input logic tlp, input logic dllp, input logic ferr);
        exp_t e;
        e.b = b; e.code = code; e.tlp = tlp; e.dllp = dllp; e.ferr = ferr;
        q_k.push_back(e);
        if (code != 4'b0010) q_d.push_back(e);
    endtask

    task automatic set_lanes(input logic [31:0] g, input logic v);
        bus_d.rx_lane0 = g[31:24]; bus_d.rx_lane1 = g[23:16];
        bus_d.rx_lane2 = g[15:8];  bus_d.rx_lane3 = g[7:0];
        bus_k.rx_lane0 = g[31:24]; bus_k.rx_lane1 = g[23:16];
        bus_k.rx_lane2 = g[15:8];  bus_k.rx_lane3 = g[7:0];
        bus_d.rx_lanes_valid = v;
        bus_k.rx_lanes_valid = v;
    endtask

    task automatic drive(input logic [31:0] g);
        @(negedge clk);
        set_lanes(g, 1'b1);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        set_lanes(32'h0, 1'b0);
        repeat (n - 1) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (bus_d.rx_byte_valid) begin
                checks++;
                if (q_d.size() == 0) begin
                    errors++;
                    $display("FAIL drop_unexpected byte=%h code=%b", bus_d.rx_byte, bus_d.control_dk);
                end else begin
                    exp_t e;
                    e = q_d.pop_front();
                    if ({bus_d.rx_byte, bus_d.control_dk, bus_d.in_tlp, bus_d.in_dllp, bus_d.framing_err}
                        !== {e.b, e.code, e.tlp, e.dllp, e.ferr}) begin
                        errors++;
                        $display("FAIL drop_stream got b=%h c=%b t=%b d=%b e=%b want b=%h c=%b t=%b d=%b e=%b",
                                 bus_d.rx_byte, bus_d.control_dk, bus_d.in_tlp, bus_d.in_dllp,
                                 bus_d.framing_err, e.b, e.code, e.tlp, e.dllp, e.ferr);
                    end
                end
            end else begin
                checks++;
                if (bus_d.framing_err !== 1'b0) begin
                    errors++;
                    $display("FAIL drop_ferr_no_byte got %b want 0", bus_d.framing_err);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (bus_k.rx_byte_valid) begin
                checks++;
                if (q_k.size() == 0) begin
                    errors++;
                    $display("FAIL keep_unexpected byte=%h code=%b", bus_k.rx_byte, bus_k.control_dk);
                end else begin
                    exp_t e;
                    e = q_k.pop_front();
                    if ({bus_k.rx_byte, bus_k.control_dk, bus_k.in_tlp, bus_k.in_dllp, bus_k.framing_err}
                        !== {e.b, e.code, e.tlp, e.dllp, e.ferr}) begin
                        errors++;
                        $display("FAIL keep_stream got b=%h c=%b t=%b d=%b e=%b want b=%h c=%b t=%b d=%b e=%b",
                                 bus_k.rx_byte, bus_k.control_dk, bus_k.in_tlp, bus_k.in_dllp,
                                 bus_k.framing_err, e.b, e.code, e.tlp, e.dllp, e.ferr);
                    end
                end
            end else begin
                checks++;
                if (bus_k.framing_err !== 1'b0) begin
                    errors++;
                    $display("FAIL keep_ferr_no_byte got %b want 0", bus_k.framing_err);
                end
            end
        end
    end

    task automatic test_reset();
        set_lanes(32'h0, 1'b0);
        rst = 1'b0;
        enb = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_d.rx_byte, bus_d.control_dk, bus_d.rx_byte_valid, bus_d.in_tlp, bus_d.in_dllp,
             bus_d.framing_err, bus_d.overflow} !== 18'h0) begin
            errors++;
            $display("FAIL reset_state got b=%h c=%b v=%b ovf=%b want all zero",
                     bus_d.rx_byte, bus_d.control_dk, bus_d.rx_byte_valid, bus_d.overflow);
        end
        rst = 1'b1;
        enb = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle_latency();
        for (int i = 0; i < 4; i++) push_exp(8'h7C, 4'b1000, 1'b0, 1'b0, 1'b0);
        drive(32'h7C7C7C7C);
        @(negedge clk);
        set_lanes(32'h0, 1'b0);
        checks++;
        if (bus_d.rx_byte_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got valid=%b want 0", bus_d.rx_byte_valid);
        end
        @(negedge clk);
        checks++;
        if ({bus_d.rx_byte_valid, bus_d.rx_byte} !== {1'b1, 8'h7C}) begin
            errors++;
            $display("FAIL latency_first got valid=%b b=%h want 1 7c", bus_d.rx_byte_valid, bus_d.rx_byte);
        end
        idle(8);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) push_exp(8'hBC, 4'b0001, 1'b0, 1'b0, 1'b0);
        push_exp(8'hFB, 4'b0011, 1'b1, 1'b0, 1'b0);
        push_exp(8'hFF, 4'b0000, 1'b1, 1'b0, 1'b0);
        push_exp(8'hFF, 4'b0000, 1'b1, 1'b0, 1'b0);
        push_exp(8'hFD, 4'b0101, 1'b1, 1'b0, 1'b0);
        drive(32'hBCBCBCBC);
        drive(32'hFBFFFFFD);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) set_lanes(32'h0, 1'b0);
            checks++;
            if (bus_k.rx_byte_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_gap cycle=%0d got valid=%b want 1", i, bus_k.rx_byte_valid);
            end
        end
        @(negedge clk);
        checks++;
        if ({bus_k.rx_byte_valid, bus_k.in_tlp} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_tail got valid=%b in_tlp=%b want 0 0", bus_k.rx_byte_valid, bus_k.in_tlp);
        end
        idle(4);
    endtask

    task automatic test_skp();
        int cnt_d;
        int cnt_k;
        cnt_d = 0;
        cnt_k = 0;
        for (int i = 0; i < 4; i++) push_exp(8'hBC, 4'b0001, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) push_exp(8'h1C, 4'b0010, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) push_exp(8'hBC, 4'b0001, 1'b0, 1'b0, 1'b0);
        // Third group lands on the edge that frees the first slot.
        for (int cyc = 0; cyc < 18; cyc++) begin
            @(negedge clk);
            case (cyc)
                0:       set_lanes(32'hBCBCBCBC, 1'b1);
                1:       set_lanes(32'h1C1C1C1C, 1'b1);
                4:       set_lanes(32'hBCBCBCBC, 1'b1);
                default: set_lanes(32'h0, 1'b0);
            endcase
            if (bus_d.rx_byte_valid) cnt_d++;
            if (bus_k.rx_byte_valid) cnt_k++;
        end
        checks++;
        if (cnt_d != 8) begin
            errors++;
            $display("FAIL skp_drop_count got %0d want 8", cnt_d);
        end
        checks++;
        if (cnt_k != 12) begin
            errors++;
            $display("FAIL skp_keep_count got %0d want 12", cnt_k);
        end
        checks++;
        if (bus_d.overflow !== 1'b0) begin
            errors++;
            $display("FAIL skp_same_edge_free got overflow=%b want 0", bus_d.overflow);
        end
    endtask

    task automatic test_framing_err();
        push_exp(8'hFF, 4'b0000, 1'b0, 1'b0, 1'b1);
        push_exp(8'hFF, 4'b0000, 1'b0, 1'b0, 1'b1);
        push_exp(8'hFD, 4'b0101, 1'b0, 1'b0, 1'b1);
        push_exp(8'h7C, 4'b1000, 1'b0, 1'b0, 1'b0);
        drive(32'hFFFFFD7C);
        idle(8);
    endtask

    task automatic test_enb();
        enb = 1'b0;
        drive(32'hFB000000);
        drive(32'hFB000000);
        drive(32'hFB000000);
        idle(6);
        checks++;
        if ({bus_d.overflow, bus_k.overflow} !== 2'b00) begin
            errors++;
            $display("FAIL enb_low_overflow got %b%b want 00", bus_d.overflow, bus_k.overflow);
        end
        enb = 1'b1;
        push_exp(8'h7C, 4'b1000, 1'b0, 1'b0, 1'b0);
        push_exp(8'hBC, 4'b0001, 1'b0, 1'b0, 1'b0);
        push_exp(8'h7C, 4'b1000, 1'b0, 1'b0, 1'b0);
        push_exp(8'hBC, 4'b0001, 1'b0, 1'b0, 1'b0);
        drive(32'h7CBC7CBC);
        @(negedge clk);
        set_lanes(32'h0, 1'b0);
        enb = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus_d.rx_byte_valid, bus_k.rx_byte_valid} !== 2'b00) begin
            errors++;
            $display("FAIL enb_freeze got valid=%b%b want 00", bus_d.rx_byte_valid, bus_k.rx_byte_valid);
        end
        enb = 1'b1;
        idle(8);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 2; i++) begin
            push_exp(8'hBC, 4'b0001, 1'b0, 1'b0, 1'b0);
            push_exp(8'h7C, 4'b1000, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            push_exp(8'h7C, 4'b1000, 1'b0, 1'b0, 1'b0);
            push_exp(8'hBC, 4'b0001, 1'b0, 1'b0, 1'b0);
        end
        drive(32'hBC7CBC7C);
        drive(32'h7CBC7CBC);
        checks++;
        if (bus_d.overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_first got %b want 0", bus_d.overflow);
        end
        drive(32'h3C3C3C3C);
        checks++;
        if (bus_d.overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_second got %b want 0", bus_d.overflow);
        end
        @(negedge clk);
        set_lanes(32'h0, 1'b0);
        checks++;
        if ({bus_d.overflow, bus_k.overflow} !== 2'b11) begin
            errors++;
            $display("FAIL ovf_third got %b%b want 11", bus_d.overflow, bus_k.overflow);
        end
        idle(12);
        checks++;
        if (bus_d.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got %b want 1", bus_d.overflow);
        end
    endtask

    task automatic test_reset_mid_dllp();
        bit seen;
        seen = 1'b0;
        push_exp(8'h5C, 4'b0100, 1'b0, 1'b1, 1'b0);
        drive(32'h5C001122);
        drive(32'h33445566);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            set_lanes(32'h0, 1'b0);
            if (bus_d.in_dllp === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL dllp_wait got in_dllp=%b want 1 within 10 cycles", bus_d.in_dllp);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({bus_d.rx_byte, bus_d.control_dk, bus_d.rx_byte_valid, bus_d.in_tlp, bus_d.in_dllp,
             bus_d.framing_err, bus_d.overflow} !== 18'h0) begin
            errors++;
            $display("FAIL async_reset got b=%h c=%b v=%b dllp=%b ovf=%b want all zero",
                     bus_d.rx_byte, bus_d.control_dk, bus_d.rx_byte_valid, bus_d.in_dllp, bus_d.overflow);
        end
        q_d.delete();
        q_k.delete();
        @(negedge clk);
        rst = 1'b1;
        push_exp(8'h5C, 4'b0100, 1'b0, 1'b1, 1'b0);
        push_exp(8'hAA, 4'b0000, 1'b0, 1'b1, 1'b0);
        push_exp(8'hBB, 4'b0000, 1'b0, 1'b1, 1'b0);
        push_exp(8'hFE, 4'b0110, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) push_exp(8'hBC, 4'b0001, 1'b0, 1'b0, 1'b0);
        drive(32'h5CAABBFE);
        drive(32'hBCBCBCBC);
        idle(12);
        checks++;
        if ({bus_d.overflow, bus_d.in_dllp} !== 2'b00) begin
            errors++;
            $display("FAIL post_reset got ovf=%b in_dllp=%b want 0 0", bus_d.overflow, bus_d.in_dllp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_idle_latency();
        test_back_to_back();
        test_skp();
        test_framing_err();
        test_enb();
        test_overflow();
        test_reset_mid_dllp();
        checks++;
        if (q_d.size() != 0 || q_k.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected got drop=%0d keep=%0d want 0 0", q_d.size(), q_k.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
